// File: rtl/mac_rx_bram_writer.sv
// Receive-side writer: MAC RX byte stream -> port A of a 32-bit byte-write BRAM.
// Frames go into a circular word buffer, each prefixed by one header word
// {bad, 15'b0, byte_len}. A frame is committed (wr_ptr_o advances) only when it is
// complete and accepted; everything else is rewound by leaving wr_ptr_o untouched.
// Optional feature macro: RX_BRAM_BADFRAME_KEEP_EN (commit bad frames with header bit 31 set).
module mac_rx_bram_writer #(
  parameter int unsigned ADDR_W          = 9,
  parameter int unsigned MAX_FRAME_BYTES = 1522
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic [7:0]        rx_tdata_i,
  input  logic              rx_tvalid_i,
  input  logic              rx_tlast_i,
  input  logic              rx_tuser_i,
  input  logic [ADDR_W-1:0] rd_ptr_i,
  output logic              bram_en_o,
  output logic [3:0]        bram_we_o,
  output logic [ADDR_W-1:0] bram_addr_o,
  output logic [31:0]       bram_din_o,
  output logic [ADDR_W-1:0] wr_ptr_o,
  output logic              frame_commit_o,
  output logic [15:0]       frame_len_o,
  output logic [15:0]       drop_cnt_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DATA = 2'd1;
  localparam logic [1:0] HDR  = 2'd2;
  localparam logic [1:0] DROP = 2'd3;

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [15:0]       MAX_LEN  = 16'(MAX_FRAME_BYTES);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] hdr_q, hdr_d;       // header word of the frame in progress
  logic [ADDR_W-1:0] word_q, word_d;     // word holding the most recently accepted byte
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [15:0]       len_q, len_d;       // bytes accepted so far in this frame
  logic              bad_q, bad_d;
  logic              commit_q, commit_d;
  logic [15:0]       frame_len_q, frame_len_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;
  logic              en_q, en_d;
  logic [3:0]        we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       din_q, din_d;
  logic              drop_inc;
  logic              keep_frame;
  logic              new_word;
  logic [ADDR_W-1:0] word_nxt;

  // A word may be written unless doing so would make the ring look empty.
  function automatic logic writable(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] rd);
    return (a + ADDR_ONE) != rd;
  endfunction

`ifdef RX_BRAM_BADFRAME_KEEP_EN
  assign keep_frame = 1'b1;
`else
  assign keep_frame = !rx_tuser_i;
`endif

  assign new_word = (len_q[1:0] == 2'd0);
  assign word_nxt = word_q + ADDR_ONE;

  // Next-state: frame FSM, byte packing, header write and commit.
  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    word_d      = word_q;
    wr_ptr_d    = wr_ptr_q;
    len_d       = len_q;
    bad_d       = bad_q;
    commit_d    = 1'b0;
    frame_len_d = frame_len_q;
    en_d        = 1'b0;
    we_d        = 4'h0;
    addr_d      = addr_q;
    din_d       = din_q;
    drop_inc    = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_tvalid_i) begin
          hdr_d  = wr_ptr_q;
          word_d = wr_ptr_q + ADDR_ONE;
          len_d  = 16'd1;
          if (!writable(wr_ptr_q, rd_ptr_i) || !writable(wr_ptr_q + ADDR_ONE, rd_ptr_i)) begin
            if (rx_tlast_i) drop_inc = 1'b1;
            else            state_d  = DROP;
          end else begin
            en_d   = 1'b1;
            we_d   = 4'b0001;
            addr_d = wr_ptr_q + ADDR_ONE;
            din_d  = {4{rx_tdata_i}};
            if (!rx_tlast_i) begin
              state_d = DATA;
            end else if (keep_frame) begin
              state_d = HDR;
              bad_d   = rx_tuser_i;
            end else begin
              drop_inc = 1'b1;
            end
          end
        end
      end
      DATA: begin
        if (rx_tvalid_i) begin
          if ((new_word && !writable(word_nxt, rd_ptr_i)) || (len_q >= MAX_LEN)) begin
            if (rx_tlast_i) begin
              state_d  = IDLE;
              drop_inc = 1'b1;
            end else begin
              state_d = DROP;
            end
          end else begin
            len_d  = len_q + 16'd1;
            word_d = new_word ? word_nxt : word_q;
            en_d   = 1'b1;
            we_d   = 4'b0001 << len_q[1:0];
            addr_d = new_word ? word_nxt : word_q;
            din_d  = {4{rx_tdata_i}};
            if (rx_tlast_i) begin
              if (keep_frame) begin
                state_d = HDR;
                bad_d   = rx_tuser_i;
              end else begin
                state_d  = IDLE;
                drop_inc = 1'b1;
              end
            end
          end
        end
      end
      HDR: begin
        en_d        = 1'b1;
        we_d        = 4'hF;
        addr_d      = hdr_q;
        din_d       = {bad_q, 15'd0, len_q};
        wr_ptr_d    = word_nxt;
        commit_d    = 1'b1;
        frame_len_d = len_q;
        state_d     = IDLE;
        // A byte here violates the inter-frame gap; it starts a frame we cannot keep.
        if (rx_tvalid_i) begin
          if (rx_tlast_i) drop_inc = 1'b1;
          else            state_d  = DROP;
        end
      end
      DROP: begin
        if (rx_tvalid_i && rx_tlast_i) begin
          state_d  = IDLE;
          drop_inc = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    drop_cnt_d = (drop_inc && (drop_cnt_q != 16'hFFFF)) ? drop_cnt_q + 16'd1 : drop_cnt_q;
  end

  // State and registered BRAM / status outputs.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      hdr_q       <= '0;
      word_q      <= '0;
      wr_ptr_q    <= '0;
      len_q       <= '0;
      bad_q       <= 1'b0;
      commit_q    <= 1'b0;
      frame_len_q <= '0;
      drop_cnt_q  <= '0;
      en_q        <= 1'b0;
      we_q        <= '0;
      addr_q      <= '0;
      din_q       <= '0;
    end else begin
      state_q     <= state_d;
      hdr_q       <= hdr_d;
      word_q      <= word_d;
      wr_ptr_q    <= wr_ptr_d;
      len_q       <= len_d;
      bad_q       <= bad_d;
      commit_q    <= commit_d;
      frame_len_q <= frame_len_d;
      drop_cnt_q  <= drop_cnt_d;
      en_q        <= en_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
    end
  end

  assign bram_en_o      = en_q;
  assign bram_we_o      = we_q;
  assign bram_addr_o    = addr_q;
  assign bram_din_o     = din_q;
  assign wr_ptr_o       = wr_ptr_q;
  assign frame_commit_o = commit_q;
  assign frame_len_o    = frame_len_q;
  assign drop_cnt_o     = drop_cnt_q;

endmodule

// File: tb/tb_mac_rx_bram_writer.sv
// Bench for mac_rx_bram_writer: a 512-word instance (dut_a) and a 32-word instance (dut_b)
// share the RX byte lines; sel chooses which one sees rx_tvalid_i.
// Expected BRAM writes are queued by a frame model and popped as the DUT writes.
module tb_mac_rx_bram_writer;

`ifdef RX_BRAM_BADFRAME_KEEP_EN
  localparam bit KEEP = 1'b1;
`else
  localparam bit KEEP = 1'b0;
`endif
  localparam int MAX = 1522;

  typedef struct packed {
    logic [8:0]  addr;
    logic [3:0]  we;
    logic [31:0] din;
  } wr_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  tdata = '0;
  logic        tvalid = 1'b0, tlast = 1'b0, tuser = 1'b0;
  logic        sel = 1'b0;
  logic [8:0]  rd_a = '0;
  logic [4:0]  rd_b = '0;

  logic        a_en, a_commit, b_en, b_commit;
  logic [3:0]  a_we, b_we;
  logic [8:0]  a_addr, a_wr;
  logic [4:0]  b_addr, b_wr;
  logic [31:0] a_din, b_din;
  logic [15:0] a_len, a_drop, b_len, b_drop;
  logic [8:0]  cur_wr;
  logic [15:0] cur_len, cur_drop;

  int  checks = 0, errors = 0;
  int  commit_seen = 0;
  int  mdl_wr = 0;
  bit  sb_on = 1'b1;
  wr_t exp_q[$];

  always #5 clk = ~clk;

  mac_rx_bram_writer #(.ADDR_W(9), .MAX_FRAME_BYTES(MAX)) dut_a (
    .clk_i(clk), .rstn_i(rstn), .rx_tdata_i(tdata), .rx_tvalid_i(tvalid & ~sel),
    .rx_tlast_i(tlast), .rx_tuser_i(tuser), .rd_ptr_i(rd_a),
    .bram_en_o(a_en), .bram_we_o(a_we), .bram_addr_o(a_addr), .bram_din_o(a_din),
    .wr_ptr_o(a_wr), .frame_commit_o(a_commit), .frame_len_o(a_len), .drop_cnt_o(a_drop)
  );

  mac_rx_bram_writer #(.ADDR_W(5), .MAX_FRAME_BYTES(MAX)) dut_b (
    .clk_i(clk), .rstn_i(rstn), .rx_tdata_i(tdata), .rx_tvalid_i(tvalid & sel),
    .rx_tlast_i(tlast), .rx_tuser_i(tuser), .rd_ptr_i(rd_b),
    .bram_en_o(b_en), .bram_we_o(b_we), .bram_addr_o(b_addr), .bram_din_o(b_din),
    .wr_ptr_o(b_wr), .frame_commit_o(b_commit), .frame_len_o(b_len), .drop_cnt_o(b_drop)
  );

  assign cur_wr   = sel ? {4'b0, b_wr} : a_wr;
  assign cur_len  = sel ? b_len : a_len;
  assign cur_drop = sel ? b_drop : a_drop;

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    wr_t got, e;
    logic other_en, m_en;
    m_en     = sel ? b_en : a_en;
    other_en = sel ? a_en : b_en;
    got.addr = sel ? {4'b0, b_addr} : a_addr;
    got.we   = sel ? b_we : a_we;
    got.din  = sel ? b_din : a_din;
    if (rstn) begin
      if (sel ? b_commit : a_commit) commit_seen++;
      if (other_en) begin
        checks++; errors++;
        $display("FAIL unselected_dut_write got en=1 want en=0");
      end
      if (m_en && sb_on) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_write got addr=%0d we=%b din=%h want no write",
                   got.addr, got.we, got.din);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL sb_write got addr=%0d we=%b din=%h want addr=%0d we=%b din=%h",
                     got.addr, got.we, got.din, e.addr, e.we, e.din);
          end
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  function automatic bit wr_ok(input int a, input int rd, input int mask);
    return ((a + 1) & mask) != rd;
  endfunction

  // Pushes the writes a frame should produce; returns the expected drop (1) or commit (0).
  task automatic model_frame(input int n, input logic [7:0] base, input bit user,
                             output bit dropped);
    int mask, rd, hdr, word;
    bit drop;
    wr_t e;
    mask = sel ? 31 : 511;
    rd   = sel ? int'(rd_b) : int'(rd_a);
    hdr  = mdl_wr;
    word = (hdr + 1) & mask;
    drop = !wr_ok(hdr, rd, mask) || !wr_ok(word, rd, mask);
    for (int k = 0; k < n; k++) begin
      if (!drop && k > 0 && (k % 4) == 0) begin
        if (!wr_ok((word + 1) & mask, rd, mask)) drop = 1'b1;
        else word = (word + 1) & mask;
      end
      if (!drop && k >= MAX) drop = 1'b1;
      if (!drop) begin
        e.addr = 9'(word);
        e.we   = 4'(1 << (k % 4));
        e.din  = {4{base + 8'(k)}};
        exp_q.push_back(e);
      end
    end
    dropped = drop || (user && !KEEP);
    if (!dropped) begin
      e.addr = 9'(hdr);
      e.we   = 4'hF;
      e.din  = {user, 15'd0, 16'(n)};
      exp_q.push_back(e);
      mdl_wr = (word + 1) & mask;
    end
  endtask

  task automatic drive_frame(input int n, input logic [7:0] base, input bit user);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      tvalid = 1'b1;
      tdata  = base + 8'(k);
      tlast  = (k == n - 1);
      tuser  = user && (k == n - 1);
    end
  endtask

  task automatic idle(input int c);
    repeat (c) begin
      @(posedge clk); #1;
      tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
    end
  endtask

  task automatic frame(input int n, input logic [7:0] base, input bit user);
    bit d;
    model_frame(n, base, user, d);
    drive_frame(n, base, user);
    idle(4);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_pending_writes got %0d outstanding want 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic do_reset(input logic s);
    @(posedge clk); #1;
    tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
    sel = s; rstn = 1'b0;
    exp_q.delete(); mdl_wr = 0; commit_seen = 0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    checks++;
    if ({a_en, a_we, a_addr, a_din} !== '0) begin
      errors++;
      $display("FAIL reset_bram got en=%b we=%b addr=%0d din=%h want all 0", a_en, a_we,
               a_addr, a_din);
    end
    checks++;
    if ({a_wr, a_commit, a_len, a_drop} !== '0) begin
      errors++;
      $display("FAIL reset_status got wr=%0d commit=%b len=%0d drop=%0d want all 0", a_wr,
               a_commit, a_len, a_drop);
    end
    checks++;
    if ({b_en, b_wr, b_drop} !== '0) begin
      errors++;
      $display("FAIL reset_dut_b got en=%b wr=%0d drop=%0d want 0", b_en, b_wr, b_drop);
    end
  endtask

  task automatic test_good_frame();
    do_reset(1'b0); rd_a = '0;
    frame(64, 8'h00, 1'b0);
    drain("good");
    checks++;
    if (cur_wr !== 9'd17) begin errors++; $display("FAIL good_wr_ptr got %0d want 17", cur_wr); end
    checks++;
    if (commit_seen != 1) begin errors++; $display("FAIL good_commits got %0d want 1", commit_seen); end
    checks++;
    if (cur_len !== 16'd64) begin errors++; $display("FAIL good_len got %0d want 64", cur_len); end
  endtask

  task automatic test_partial_word();
    do_reset(1'b0); rd_a = '0;
    frame(61, 8'h00, 1'b0);
    drain("partial");
    checks++;
    if (cur_wr !== 9'd17) begin errors++; $display("FAIL partial_wr_ptr got %0d want 17", cur_wr); end
    checks++;
    if (cur_len !== 16'd61) begin errors++; $display("FAIL partial_len got %0d want 61", cur_len); end
  endtask

  task automatic test_bad_frame();
    do_reset(1'b0); rd_a = '0;
    frame(64, 8'h00, 1'b1);
    drain("bad1");
    checks++;
    if (cur_wr !== (KEEP ? 9'd17 : 9'd0)) begin
      errors++; $display("FAIL bad_wr_ptr got %0d want %0d", cur_wr, KEEP ? 17 : 0);
    end
    checks++;
    if (cur_drop !== (KEEP ? 16'd0 : 16'd1)) begin
      errors++; $display("FAIL bad_drop got %0d want %0d", cur_drop, KEEP ? 0 : 1);
    end
    frame(64, 8'h40, 1'b0);
    drain("bad2");
    checks++;
    if (cur_wr !== (KEEP ? 9'd34 : 9'd17)) begin
      errors++; $display("FAIL bad_next_wr_ptr got %0d want %0d", cur_wr, KEEP ? 34 : 17);
    end
    checks++;
    if (commit_seen != (KEEP ? 2 : 1)) begin
      errors++; $display("FAIL bad_commits got %0d want %0d", commit_seen, KEEP ? 2 : 1);
    end
  endtask

  task automatic test_back_to_back();
    bit d;
    do_reset(1'b0); rd_a = '0;
    model_frame(8, 8'h10, 1'b0, d);
    drive_frame(8, 8'h10, 1'b0);
    drive_frame(8, 8'h20, 1'b0);  // first byte lands on the header cycle
    idle(4);
    frame(4, 8'h30, 1'b0);
    drain("b2b");
    checks++;
    if (cur_wr !== 9'd5) begin errors++; $display("FAIL b2b_wr_ptr got %0d want 5", cur_wr); end
    checks++;
    if (cur_drop !== 16'd1) begin errors++; $display("FAIL b2b_drop got %0d want 1", cur_drop); end
    checks++;
    if (commit_seen != 2) begin errors++; $display("FAIL b2b_commits got %0d want 2", commit_seen); end
    checks++;
    if (cur_len !== 16'd4) begin errors++; $display("FAIL b2b_len got %0d want 4", cur_len); end
  endtask

  task automatic test_overflow();
    do_reset(1'b1); rd_b = '0;
    frame(200, 8'h00, 1'b0);
    drain("ovf");
    checks++;
    if (cur_drop !== 16'd1) begin errors++; $display("FAIL ovf_drop got %0d want 1", cur_drop); end
    checks++;
    if (cur_wr !== 9'd0) begin errors++; $display("FAIL ovf_wr_ptr got %0d want 0", cur_wr); end
    checks++;
    if (commit_seen != 0) begin errors++; $display("FAIL ovf_commits got %0d want 0", commit_seen); end
  endtask

  task automatic test_wrap();
    do_reset(1'b1); rd_b = '0;
    frame(108, 8'h00, 1'b0);
    drain("wrap_fill");
    checks++;
    if (cur_wr !== 9'd28) begin errors++; $display("FAIL wrap_fill_wr_ptr got %0d want 28", cur_wr); end
    rd_b = 5'd28;
    frame(20, 8'h80, 1'b0);
    drain("wrap");
    checks++;
    if (cur_wr !== 9'd2) begin errors++; $display("FAIL wrap_wr_ptr got %0d want 2", cur_wr); end
    checks++;
    if (commit_seen != 2) begin errors++; $display("FAIL wrap_commits got %0d want 2", commit_seen); end
  endtask

  task automatic test_oversize();
    do_reset(1'b0); rd_a = '0;
    frame(1530, 8'h00, 1'b0);
    drain("oversize");
    checks++;
    if (cur_drop !== 16'd1) begin errors++; $display("FAIL oversize_drop got %0d want 1", cur_drop); end
    checks++;
    if (cur_wr !== 9'd0) begin errors++; $display("FAIL oversize_wr_ptr got %0d want 0", cur_wr); end
    frame(MAX, 8'h00, 1'b0);
    drain("maxlen");
    checks++;
    if (cur_wr !== 9'd382) begin errors++; $display("FAIL maxlen_wr_ptr got %0d want 382", cur_wr); end
    checks++;
    if (cur_len !== 16'd1522) begin errors++; $display("FAIL maxlen_len got %0d want 1522", cur_len); end
  endtask

  task automatic test_reset_midframe();
    do_reset(1'b0); rd_a = '0;
    frame(8, 8'h00, 1'b0);
    drain("pre_rst");
    sb_on = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      tvalid = 1'b1; tdata = 8'(k); tlast = 1'b0; tuser = 1'b0;
    end
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    checks++;
    if ({a_en, a_we, a_addr, a_din, a_wr, a_commit, a_len, a_drop} !== '0) begin
      errors++;
      $display("FAIL async_reset got en=%b we=%b addr=%0d din=%h wr=%0d len=%0d want all 0",
               a_en, a_we, a_addr, a_din, a_wr, a_len);
    end
    tvalid = 1'b0;
    exp_q.delete(); mdl_wr = 0; commit_seen = 0;
    @(posedge clk); #1;
    rstn = 1'b1; sb_on = 1'b1;
    frame(8, 8'h55, 1'b0);
    drain("post_rst");
    checks++;
    if (cur_wr !== 9'd3) begin errors++; $display("FAIL post_rst_wr_ptr got %0d want 3", cur_wr); end
    checks++;
    if (commit_seen != 1) begin errors++; $display("FAIL post_rst_commits got %0d want 1", commit_seen); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_partial_word();
    test_bad_frame();
    test_back_to_back();
    test_overflow();
    test_wrap();
    test_oversize();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
